// File: rtl/alu_arbiter_if.sv
// Bus interface for alu_arbiter: the requester handshake, the response
// handshake and the link to the shared combinational ALU.
// The arbiter connects through the slave modport. The master modport is the
// view seen by the requesters and the ALU together.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb;
  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ-1:0]               rsp_ready;
  logic [DATA_WIDTH-1:0]            rsp_data;
  logic                             rsp_err;
  logic [DATA_WIDTH-1:0]            alu_srca;
  logic [DATA_WIDTH-1:0]            alu_srcb;
  logic [OPCODE_LENGTH-1:0]         alu_op;
  logic [DATA_WIDTH-1:0]            alu_result;

  modport slave (
    input  req_valid, req_srca, req_srcb, req_op, rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, alu_srca, alu_srcb, alu_op
  );

  modport master (
    output req_valid, req_srca, req_srcb, req_op, rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, alu_srca, alu_srcb, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ
// requesters. Operands are registered before the ALU and the result is
// registered after it. IDLE -> EXEC -> RESP gives at least 3 cycles per op.
// Optional macro ALU_ARB_OPCHECK_EN: flag illegal opcodes on rsp_err.
// Without it, rsp_err is constant 0.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state_q, state_d;
  logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]      owner_q, owner_d;
  logic [DATA_WIDTH-1:0]    srca_q, srcb_q, rsp_data_q;
  logic [OPCODE_LENGTH-1:0] op_q;

  logic                     grant_vld;
  logic [ID_WIDTH-1:0]      grant_id;
  logic                     accept;
  logic [NUM_REQ-1:0]       req_ready_c;
  logic [NUM_REQ-1:0]       rsp_valid_c;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_id  = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    accept      = 1'b0;
    req_ready_c = '0;
    rsp_valid_c = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          accept                = 1'b1;
          req_ready_c[grant_id] = 1'b1;
          owner_d               = grant_id;
          rr_ptr_d              = ID_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
          state_d               = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_c[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer and current owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Operand/opcode capture on accept; held afterwards so the ALU inputs stay put
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srca_q <= '0;
      srcb_q <= '0;
      op_q   <= '0;
    end else if (accept) begin
      srca_q <= bus.req_srca[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      srcb_q <= bus.req_srcb[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      op_q   <= bus.req_op[int'(grant_id)*OPCODE_LENGTH +: OPCODE_LENGTH];
    end
  end

  // Result capture, only on the EXEC->RESP edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_q <= '0;
    end else if (state_q == EXEC) begin
      rsp_data_q <= bus.alu_result;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_q;

  function automatic logic op_legal(input logic [OPCODE_LENGTH-1:0] op);
    return op inside {OPCODE_LENGTH'(0), OPCODE_LENGTH'(1), OPCODE_LENGTH'(2),
                      OPCODE_LENGTH'(3), OPCODE_LENGTH'(4), OPCODE_LENGTH'(8),
                      OPCODE_LENGTH'(9)};
  endfunction

  // Illegal-opcode flag, recomputed together with each result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_err_q <= !op_legal(op_q);
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // req_ready is combinational, so mask it while reset is held
  assign bus.req_ready = req_ready_c & {NUM_REQ{~reset}};
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.alu_srca  = srca_q;
  assign bus.alu_srcb  = srcb_q;
  assign bus.alu_op    = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: a 2-requester instance for most
// scenarios and a 3-requester instance for the round-robin wrap case.
// A small reference ALU drives alu_result for both instances.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .NUM_REQ(2)) bus2 ();
  alu_arbiter_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .NUM_REQ(3)) bus3 ();

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .NUM_REQ(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .NUM_REQ(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  // Reference ALU: AND, XOR, SUB, OR, ADD, EQ, SLT; anything else gives 0
  function automatic logic [31:0] alu_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a ^ b;
      4'b0010: return a - b;
      4'b0011: return a | b;
      4'b0100: return a + b;
      4'b1000: return {31'd0, a == b};
      4'b1001: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  assign bus2.alu_result = alu_model(bus2.alu_op, bus2.alu_srca, bus2.alu_srcb);
  assign bus3.alu_result = alu_model(bus3.alu_op, bus3.alu_srca, bus3.alu_srcb);

`ifdef ALU_ARB_OPCHECK_EN
  localparam logic ERR_ON_ILLEGAL = 1'b1;
`else
  localparam logic ERR_ON_ILLEGAL = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus2.req_valid = 2'b11;
    #1;
    checks++;
    if (bus2.req_ready !== 2'b00) begin
      $display("FAIL reset_req_ready got=%b exp=00", bus2.req_ready); errors++;
    end
    checks++;
    if (bus2.rsp_valid !== 2'b00 || bus2.rsp_data !== 32'd0 || bus2.rsp_err !== 1'b0) begin
      $display("FAIL reset_rsp got valid=%b data=%0h err=%b exp 00/0/0",
               bus2.rsp_valid, bus2.rsp_data, bus2.rsp_err); errors++;
    end
    checks++;
    if (bus2.alu_srca !== 32'd0 || bus2.alu_srcb !== 32'd0 || bus2.alu_op !== 4'd0) begin
      $display("FAIL reset_alu got a=%0h b=%0h op=%0h exp 0/0/0",
               bus2.alu_srca, bus2.alu_srcb, bus2.alu_op); errors++;
    end
    bus2.req_valid = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    $display("txn reset: checked idle outputs");
  endtask

  task automatic test_single();
    bus2.req_srca[31:0] = 32'd5;
    bus2.req_srcb[31:0] = 32'd3;
    bus2.req_op[3:0]    = 4'b0100;
    bus2.req_valid      = 2'b01;
    #1;
    checks++;
    if (bus2.req_ready !== 2'b01) begin
      $display("FAIL single_ready got=%b exp=01", bus2.req_ready); errors++;
    end
    tick();
    bus2.req_valid = 2'b00;
    #1;
    checks++;
    if (bus2.alu_srca !== 32'd5 || bus2.alu_srcb !== 32'd3 || bus2.alu_op !== 4'b0100 ||
        bus2.rsp_valid !== 2'b00) begin
      $display("FAIL single_exec got a=%0d b=%0d op=%b rv=%b exp 5/3/0100/00",
               bus2.alu_srca, bus2.alu_srcb, bus2.alu_op, bus2.rsp_valid); errors++;
    end
    tick();
    checks++;
    if (bus2.rsp_valid !== 2'b01 || bus2.rsp_data !== 32'd8) begin
      $display("FAIL single_rsp got valid=%b data=%0d exp 01/8", bus2.rsp_valid, bus2.rsp_data);
      errors++;
    end
    bus2.rsp_ready = 2'b01;
    tick();
    bus2.rsp_ready = 2'b00;
    // Back-to-back: req1 (2 AND 3) is accepted in the very next cycle
    bus2.req_srca[63:32] = 32'd2;
    bus2.req_srcb[63:32] = 32'd3;
    bus2.req_op[7:4]     = 4'b0000;
    bus2.req_valid       = 2'b10;
    #1;
    checks++;
    if (bus2.rsp_valid !== 2'b00 || bus2.req_ready !== 2'b10) begin
      $display("FAIL single_next got rv=%b rdy=%b exp 00/10", bus2.rsp_valid, bus2.req_ready);
      errors++;
    end
    tick();
    bus2.req_valid = 2'b00;
    tick();
    checks++;
    if (bus2.rsp_valid !== 2'b10 || bus2.rsp_data !== 32'd2) begin
      $display("FAIL single_next_rsp got valid=%b data=%0d exp 10/2", bus2.rsp_valid, bus2.rsp_data);
      errors++;
    end
    bus2.rsp_ready = 2'b10;
    tick();
    bus2.rsp_ready = 2'b00;
    $display("txn single: 5+3 and 2&3 served");
  endtask

  task automatic test_contention();
    int exp_id;
    bus2.req_srca = {32'd7, 32'd10};
    bus2.req_srcb = {32'd7, 32'd4};
    bus2.req_op   = {4'b0010, 4'b0010};
    bus2.req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_id = g % 2;
      #1;
      checks++;
      if (bus2.req_ready !== 2'(1 << exp_id)) begin
        $display("FAIL contention_grant%0d got=%b exp=%b", g, bus2.req_ready, 2'(1 << exp_id));
        errors++;
      end
      tick();
      tick();
      checks++;
      if (bus2.rsp_valid !== 2'(1 << exp_id) ||
          bus2.rsp_data !== ((exp_id == 0) ? 32'd6 : 32'd0)) begin
        $display("FAIL contention_rsp%0d got valid=%b data=%0d exp %b/%0d", g,
                 bus2.rsp_valid, bus2.rsp_data, 2'(1 << exp_id), (exp_id == 0) ? 6 : 0);
        errors++;
      end
      bus2.rsp_ready = 2'(1 << exp_id);
      tick();
      bus2.rsp_ready = 2'b00;
      $display("txn contention: grant %0d to req%0d", g, exp_id);
    end
    bus2.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    bus2.req_srca  = {32'd9, 32'd10};
    bus2.req_srcb  = {32'd9, 32'd4};
    bus2.req_op    = {4'b1000, 4'b0010};
    bus2.req_valid = 2'b10;
    #1;
    checks++;
    if (bus2.req_ready !== 2'b10) begin
      $display("FAIL bp_grant1 got=%b exp=10", bus2.req_ready); errors++;
    end
    tick();
    bus2.req_valid = 2'b01;
    tick();
    // Non-owner rsp_ready must be ignored
    bus2.rsp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus2.rsp_valid !== 2'b10 || bus2.rsp_data !== 32'd1 || bus2.req_ready !== 2'b00) begin
        $display("FAIL bp_hold%0d got valid=%b data=%0d rdy=%b exp 10/1/00", c,
                 bus2.rsp_valid, bus2.rsp_data, bus2.req_ready);
        errors++;
      end
      tick();
    end
    bus2.rsp_ready = 2'b10;
    tick();
    bus2.rsp_ready = 2'b00;
    checks++;
    if (bus2.req_ready !== 2'b01) begin
      $display("FAIL bp_grant0 got=%b exp=01", bus2.req_ready); errors++;
    end
    tick();
    bus2.req_valid = 2'b00;
    tick();
    checks++;
    if (bus2.rsp_valid !== 2'b01 || bus2.rsp_data !== 32'd6) begin
      $display("FAIL bp_rsp0 got valid=%b data=%0d exp 01/6", bus2.rsp_valid, bus2.rsp_data);
      errors++;
    end
    bus2.rsp_ready = 2'b01;
    tick();
    bus2.rsp_ready = 2'b00;
    $display("txn backpressure: req1 held 5 cycles, then req0 served");
  endtask

  task automatic test_opcheck();
    bus2.req_srca[31:0] = 32'd3;
    bus2.req_srcb[31:0] = 32'd5;
    bus2.req_op[3:0]    = 4'b0111;
    bus2.req_valid      = 2'b01;
    tick();
    bus2.req_valid = 2'b00;
    tick();
    checks++;
    if (bus2.rsp_valid !== 2'b01 || bus2.rsp_data !== 32'd0 || bus2.rsp_err !== ERR_ON_ILLEGAL) begin
      $display("FAIL opcheck_illegal got valid=%b data=%0h err=%b exp 01/0/%b",
               bus2.rsp_valid, bus2.rsp_data, bus2.rsp_err, ERR_ON_ILLEGAL);
      errors++;
    end
    bus2.rsp_ready = 2'b01;
    tick();
    bus2.rsp_ready = 2'b00;
    $display("txn opcheck: op 0111");
    bus2.req_srca[31:0] = 32'h0000_00F0;
    bus2.req_srcb[31:0] = 32'h0000_00FF;
    bus2.req_op[3:0]    = 4'b0001;
    bus2.req_valid      = 2'b01;
    tick();
    bus2.req_valid = 2'b00;
    tick();
    checks++;
    if (bus2.rsp_valid !== 2'b01 || bus2.rsp_data !== 32'h0000_000F || bus2.rsp_err !== 1'b0) begin
      $display("FAIL opcheck_legal got valid=%b data=%0h err=%b exp 01/f/0",
               bus2.rsp_valid, bus2.rsp_data, bus2.rsp_err);
      errors++;
    end
    bus2.rsp_ready = 2'b01;
    tick();
    bus2.rsp_ready = 2'b00;
    $display("txn opcheck: op 0001");
  endtask

  task automatic test_wrap();
    bus3.req_srca  = {32'd0, 32'd20, 32'd11};
    bus3.req_srcb  = {32'd0, 32'd5,  32'd1};
    bus3.req_op    = {4'b0000, 4'b0100, 4'b0100};
    // req1 alone moves rr_ptr to 2
    bus3.req_valid = 3'b010;
    tick();
    bus3.req_valid = 3'b000;
    tick();
    checks++;
    if (bus3.rsp_valid !== 3'b010 || bus3.rsp_data !== 32'd25) begin
      $display("FAIL wrap_prep got valid=%b data=%0d exp 010/25", bus3.rsp_valid, bus3.rsp_data);
      errors++;
    end
    bus3.rsp_ready = 3'b010;
    tick();
    bus3.rsp_ready = 3'b000;
    // rr_ptr=2, req2 idle: search wraps to req0
    bus3.req_valid = 3'b011;
    #1;
    checks++;
    if (bus3.req_ready !== 3'b001) begin
      $display("FAIL wrap_grant got=%b exp=001", bus3.req_ready); errors++;
    end
    tick();
    tick();
    checks++;
    if (bus3.rsp_valid !== 3'b001 || bus3.rsp_data !== 32'd12) begin
      $display("FAIL wrap_rsp got valid=%b data=%0d exp 001/12", bus3.rsp_valid, bus3.rsp_data);
      errors++;
    end
    bus3.rsp_ready = 3'b001;
    tick();
    bus3.rsp_ready = 3'b000;
    // rr_ptr is now 1, so req1 wins the same tie
    checks++;
    if (bus3.req_ready !== 3'b010) begin
      $display("FAIL wrap_next got=%b exp=010", bus3.req_ready); errors++;
    end
    tick();
    bus3.req_valid = 3'b000;
    tick();
    bus3.rsp_ready = 3'b010;
    tick();
    bus3.rsp_ready = 3'b000;
    $display("txn wrap: grants req1, req0, req1 on 3-requester instance");
  endtask

  task automatic test_reset_mid_op();
    bus2.req_srca[31:0] = 32'd1;
    bus2.req_srcb[31:0] = 32'd1;
    bus2.req_op[3:0]    = 4'b0100;
    bus2.req_valid      = 2'b01;
    tick();
    bus2.req_valid = 2'b00;
    checks++;
    if (bus2.alu_srca !== 32'd1) begin
      $display("FAIL midreset_exec got a=%0d exp=1", bus2.alu_srca); errors++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus2.alu_srca !== 32'd0 || bus2.alu_op !== 4'd0 || bus2.rsp_data !== 32'd0 ||
        bus2.rsp_valid !== 2'b00 || bus2.req_ready !== 2'b00) begin
      $display("FAIL midreset_clear got a=%0d op=%0d data=%0h rv=%b rdy=%b exp all 0",
               bus2.alu_srca, bus2.alu_op, bus2.rsp_data, bus2.rsp_valid, bus2.req_ready);
      errors++;
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus2.rsp_valid !== 2'b00) begin
        $display("FAIL midreset_norsp%0d got=%b exp=00", c, bus2.rsp_valid); errors++;
      end
    end
    bus2.req_valid = 2'b11;
    #1;
    checks++;
    if (bus2.req_ready !== 2'b01) begin
      $display("FAIL midreset_tie got=%b exp=01", bus2.req_ready); errors++;
    end
    tick();
    bus2.req_valid = 2'b00;
    $display("txn reset_mid_op: aborted, req0 wins post-reset tie");
  endtask

  initial begin
    reset          = 1'b1;
    bus2.req_valid = '0;
    bus2.req_srca  = '0;
    bus2.req_srcb  = '0;
    bus2.req_op    = '0;
    bus2.rsp_ready = '0;
    bus3.req_valid = '0;
    bus3.req_srca  = '0;
    bus3.req_srcb  = '0;
    bus3.req_op    = '0;
    bus3.rsp_ready = '0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_opcheck();
    test_wrap();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance among NUM_REQ requesters, e.g. the integer pipeline and a future multi-cycle/CSR helper unit.
- Arbitration is round-robin. Operands and opcode are registered before they drive the ALU, and the result is registered before it is returned.
- A valid/ready handshake is used on both the request side and the response side.
- Sits between requesters and the ALU. The ALU itself is not modified.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, ALU Operation width.
- NUM_REQ, 2, number of requesters (>=2).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_srca  in  NUM_REQ*DATA_WIDTH  packed operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_srcb  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
- req_op  in  NUM_REQ*OPCODE_LENGTH  packed Operation codes.
- rsp_valid  out  NUM_REQ  per-requester response valid, one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_data  out  DATA_WIDTH  result, shared by all requesters.
- rsp_err  out  1  illegal-opcode flag (see Optional Feature).
- alu_srca  out  DATA_WIDTH  to ALU SrcA.
- alu_srcb  out  DATA_WIDTH  to ALU SrcB.
- alu_op  out  OPCODE_LENGTH  to ALU Operation.
- alu_result  in  DATA_WIDTH  from ALU ALUResult.

Behaviour:
- Reset:
  - state=IDLE, rr_ptr=0, owner=0.
  - Operand/op registers =0, so alu_srca/alu_srcb/alu_op=0.
  - rsp_data=0, rsp_err=0, req_ready=0, rsp_valid=0.
  - Reset asserted mid-transaction aborts it. No response is issued and the requester must re-request.
- FSM states:
  - IDLE:
    - If any req_valid, grant the first requester at or after rr_ptr, searching upward with wrap NUM_REQ-1 -> 0.
    - req_ready[grant]=1 combinationally in IDLE only. All other req_ready bits =0.
    - On the edge: latch srca/srcb/op and owner=grant, set rr_ptr=(grant+1) mod NUM_REQ, go to EXEC.
    - No valid: stay in IDLE, rr_ptr unchanged.
  - EXEC:
    - alu_* driven from the latched registers.
    - On the edge: rsp_data<=alu_result, rsp_err computed, go to RESP.
  - RESP:
    - rsp_valid[owner]=1. rsp_data/rsp_err held stable.
    - rsp_ready[owner]=1 -> IDLE on the edge.
    - Otherwise hold indefinitely. rsp_ready of non-owners is ignored.
- Timing and throughput:
  - Accept edge = cycle 0. rsp_valid is high from cycle 2.
  - Minimum 3 cycles per operation. No new request is accepted while in EXEC or RESP.
- Requester obligations:
  - req_valid and payload stay stable until req_ready is seen. The arbiter never drops an asserted request.
  - Deasserting req_valid before a grant is legal and is ignored.
- Ordering and fairness:
  - Simultaneous requests: lowest index at/after rr_ptr wins. Any continuously-valid requester is served within NUM_REQ grants.
- Outputs:
  - alu_* hold their last latched values when not in EXEC; do not return them to 0.
  - rsp_data is never modified outside the EXEC->RESP edge. No arithmetic is performed here; width is carried unchanged.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - In EXEC, rsp_err<=1 if the latched op is not in {0000,0001,0010,0011,0100,1000,1001}. rsp_data is still the ALU output, which is 0 for illegal codes.
  - rsp_err clears on the next EXEC->RESP edge with a legal op.
- Undefined: rsp_err is tied to constant 0.

Test Plan:
- Single request: req0 srca=5, srcb=3, op=0100 -> req_ready[0] high in the accept cycle; rsp_valid[0] two cycles later with rsp_data=8; rsp_ready[0]=1 returns to IDLE; the next request is accepted the following cycle.
- Contention: req0 and req1 valid continuously from reset, op=0010 with (10,4) and (7,7) -> grants alternate 0,1,0,1; results 6 and 0; rr_ptr toggles each grant.
- Response backpressure: rsp_ready[1]=0 for 5 cycles after rsp_valid[1] -> rsp_valid and rsp_data (op=1000, 9==9 -> 1) stable all 5 cycles; req0 valid throughout is not granted until after the RESP->IDLE edge.
- Reset mid-op: assert reset during EXEC -> all outputs 0 immediately, no rsp_valid after release, rr_ptr=0 so req0 wins the first post-reset tie.
- Opcode check (macro defined): op=0111 -> rsp_data=0, rsp_err=1; the following op=0001 with (0xF0, 0xFF) -> rsp_data=0x0F, rsp_err=0. Macro undefined: rsp_err stays 0 for both.
- Wrap: NUM_REQ=3, rr_ptr=2, req0 and req1 valid, req2 idle -> req0 granted, rr_ptr becomes 1.
